// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_pkg
// Description : Shared types and constants for the SNN frame sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package snn_pkg;

   localparam int          IMG_PIXELS = 784;
   localparam int          NUM_BYTES  = 98;
   localparam int          ADDR_W     = 10;
   localparam logic [7:0]  ASCII_OFS  = 8'h30;

   typedef enum logic [2:0] {
      WAIT_BYTE = 3'd0,
      UNPACK    = 3'd1,
      START     = 3'd2,
      COMPUTE   = 3'd3,
      TX        = 3'd4,
      WAIT_TX   = 3'd5
   } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/snn_bit_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : snn_bit_unpacker
// Description : 8-bit load/shift register with a 3-bit bit counter. Emits the
//               loaded byte LSB first, one bit per shift.
// Revision    : 1.0  initial release
// ============================================================================
module snn_bit_unpacker (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       shift,
   input  logic [7:0] din,
   output logic       bit_out,
   output logic       last,
   output logic [2:0] bit_cnt
);

   logic [7:0] shreg_q, shreg_d;
   logic [2:0] cnt_q,   cnt_d;

   // Load restarts the counter; shift moves the next pixel into bit 0.
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (load) begin
         shreg_d = din;
         cnt_d   = 3'd0;
      end else if (shift) begin
         shreg_d = {1'b0, shreg_q[7:1]};
         cnt_d   = cnt_q + 3'd1;
      end
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= 8'h00;
         cnt_q   <= 3'd0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bit_out = shreg_q[0];
   assign last    = (cnt_q == 3'd7);
   assign bit_cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/snn_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : snn_frame_ctrl
// Description : Frame sequencer: loads a packed binary image from the UART
//               into the 1-bit input RAM, starts the SNN core, and returns
//               the classified digit as ASCII over the UART and on the LEDs.
// Revision    : 1.0  initial release
// ============================================================================
module snn_frame_ctrl #(
   parameter int         NUM_BYTES = snn_pkg::NUM_BYTES,
   parameter int         ADDR_W    = snn_pkg::ADDR_W,
   parameter logic [7:0] ASCII_OFS = snn_pkg::ASCII_OFS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_rdy,
   input  logic [7:0]        rx_data,
   output logic              clr_rx_rdy,
   input  logic [ADDR_W-1:0] core_addr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic              ram_wdata,
   output logic              core_start,
   input  logic              core_done,
   input  logic [3:0]        core_digit,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_done,
   output logic [7:0]        led,
   output logic              busy
);

   import snn_pkg::*;

   localparam int                BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

   frame_state_t      state_q, state_d;
   logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]        led_q, led_d;
   logic [7:0]        tx_data_q, tx_data_d;

   logic              up_load;
   logic              up_shift;
   logic              up_bit;
   logic              up_last;
   logic [2:0]        up_bit_cnt;
   logic [ADDR_W-1:0] loader_addr;

   snn_bit_unpacker u_unpacker (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (up_load),
      .shift   (up_shift),
      .din     (rx_data),
      .bit_out (up_bit),
      .last    (up_last),
      .bit_cnt (up_bit_cnt)
   );

   // Pixel 8k+i lives at address {k,3'b000}+i.
   assign loader_addr = ADDR_W'({byte_cnt_q, 3'b000}) + ADDR_W'(up_bit_cnt);

   // Next-state, datapath updates and per-state outputs.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      led_d      = led_q;
      tx_data_d  = tx_data_q;
      clr_rx_rdy = 1'b0;
      ram_we     = 1'b0;
      core_start = 1'b0;
      tx_start   = 1'b0;
      up_load    = 1'b0;
      up_shift   = 1'b0;
      ram_addr   = loader_addr;
      case (state_q)
         WAIT_BYTE: begin
            if (rx_rdy) begin
               clr_rx_rdy = 1'b1;
               up_load    = 1'b1;
               state_d    = UNPACK;
            end
         end
         UNPACK: begin
            ram_we   = 1'b1;
            up_shift = 1'b1;
            if (up_last) begin
               if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_d = '0;
                  state_d    = START;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  state_d    = WAIT_BYTE;
               end
            end
         end
         START: begin
            ram_addr   = core_addr;
            core_start = 1'b1;
            state_d    = COMPUTE;
         end
         COMPUTE: begin
            ram_addr = core_addr;
            if (core_done) begin
               tx_data_d = ASCII_OFS + {4'h0, core_digit};
               led_d     = {4'h0, core_digit};
               state_d   = TX;
            end
         end
         TX: begin
            ram_addr = core_addr;
            tx_start = 1'b1;
            state_d  = WAIT_TX;
         end
         WAIT_TX: begin
            ram_addr = core_addr;
            if (tx_done) begin
               state_d = WAIT_BYTE;
            end
         end
         default: begin
            state_d = WAIT_BYTE;
         end
      endcase
   end

   // Sequencer registers; reset discards any partially loaded frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WAIT_BYTE;
         byte_cnt_q <= '0;
         led_q      <= 8'h00;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         led_q      <= led_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign ram_wdata = up_bit;
   assign led       = led_q;
   assign tx_data   = tx_data_q;
   assign busy      = (state_q != WAIT_BYTE);

endmodule
`default_nettype wire

// File: tb/tb_snn_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_snn_frame_ctrl
// Description : Directed self-checking bench for snn_frame_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_snn_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_rdy = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       clr_rx_rdy;
   logic [9:0] core_addr = 10'h000;
   logic [9:0] ram_addr;
   logic       ram_we;
   logic       ram_wdata;
   logic       core_start;
   logic       core_done = 1'b0;
   logic [3:0] core_digit = 4'h0;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done = 1'b0;
   logic [7:0] led;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Bench-side monitors
   logic mem [0:1023];
   int   cyc = 0;
   int   wr_cnt = 0;
   int   clr_cnt = 0;
   int   clr_cyc = 0;
   int   start_cnt = 0;
   int   start_cyc = 0;
   int   done_cyc = 0;
   int   tx_cnt = 0;
   int   txs_cyc = 0;

   always #5 clk = ~clk;

   snn_frame_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_rdy     (rx_rdy),
      .rx_data    (rx_data),
      .clr_rx_rdy (clr_rx_rdy),
      .core_addr  (core_addr),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .core_start (core_start),
      .core_done  (core_done),
      .core_digit (core_digit),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_done    (tx_done),
      .led        (led),
      .busy       (busy)
   );

   // RAM model and event recorders
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_we === 1'b1) begin
         mem[ram_addr] <= ram_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (clr_rx_rdy === 1'b1) begin
         clr_cnt <= clr_cnt + 1;
         clr_cyc <= cyc;
      end
      if (core_start === 1'b1) begin
         start_cnt <= start_cnt + 1;
         start_cyc <= cyc;
      end
      if (core_done === 1'b1) done_cyc <= cyc;
      if (tx_start === 1'b1) begin
         tx_cnt  <= tx_cnt + 1;
         txs_cyc <= cyc;
      end
   end

   function automatic logic [7:0] byte_at(input int k);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = mem[8*k + i];
      return r;
   endfunction

   // Present a byte after a gap and hold rx_rdy until it is acknowledged.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int got;
      got = 0;
      repeat (gap) @(negedge clk);
      rx_data = b;
      rx_rdy  = 1'b1;
      for (int i = 0; i < 40 && got == 0; i++) begin
         #1;
         if (clr_rx_rdy === 1'b1) got = 1;
         @(negedge clk);
      end
      rx_rdy = 1'b0;
      if (got == 0) begin
         checks++; errors++;
         $display("FAIL send_byte_timeout: clr_rx_rdy not seen, required 1");
      end
   endtask

   task automatic wait_start(input int s0);
      int i;
      i = 0;
      while (start_cnt == s0 && i < 40) begin
         @(negedge clk);
         i++;
      end
      if (start_cnt == s0) begin
         checks++; errors++;
         $display("FAIL wait_start_timeout: core_start not seen");
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (led !== 8'h00)       begin errors++; $display("FAIL reset_led: got %h want 00", led); end
      checks++; if (tx_data !== 8'h00)   begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL reset_clr: got %b want 0", clr_rx_rdy); end
      checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b want 0", core_start); end
      checks++; if (tx_start !== 1'b0)   begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
      checks++; if (ram_we !== 1'b0)     begin errors++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_frame_load();
      int w0, c0, s0;
      w0 = wr_cnt; c0 = clr_cnt; s0 = start_cnt;
      for (int k = 0; k < 98; k++) send_byte(8'hA5, k % 3);
      wait_start(s0);
      repeat (4) @(negedge clk);
      #1;
      checks++; if (wr_cnt - w0 !== 784)  begin errors++; $display("FAIL load_writes: got %0d want 784", wr_cnt - w0); end
      checks++; if (clr_cnt - c0 !== 98)  begin errors++; $display("FAIL load_clr_pulses: got %0d want 98", clr_cnt - c0); end
      checks++; if (mem[0] !== 1'b1)      begin errors++; $display("FAIL load_addr0: got %b want 1", mem[0]); end
      checks++; if (mem[1] !== 1'b0)      begin errors++; $display("FAIL load_addr1: got %b want 0", mem[1]); end
      checks++; if (mem[783] !== 1'b1)    begin errors++; $display("FAIL load_addr783: got %b want 1", mem[783]); end
      checks++; if (byte_at(40) !== 8'hA5) begin errors++; $display("FAIL load_byte40: got %h want a5", byte_at(40)); end
      checks++; if (start_cyc - clr_cyc !== 9) begin errors++; $display("FAIL load_start_latency: got %0d want 9", start_cyc - clr_cyc); end
      checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL load_single_start: got %0d want 1", start_cnt - s0); end
      checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL load_busy_compute: got %b want 1", busy); end
   endtask

   task automatic test_classify_early_byte();
      int c0, t0, w0;
      c0 = clr_cnt; t0 = tx_cnt;
      core_addr = 10'h30F;
      #1;
      checks++; if (ram_addr !== 10'h30F) begin errors++; $display("FAIL share_addr: got %h want 30f", ram_addr); end
      checks++; if (ram_we !== 1'b0)      begin errors++; $display("FAIL share_we: got %b want 0", ram_we); end
      @(negedge clk);
      rx_data = 8'h3C;
      rx_rdy  = 1'b1;
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (clr_cnt !== c0)       begin errors++; $display("FAIL early_no_clr: got %0d want %0d", clr_cnt, c0); end
      checks++; if (tx_cnt !== t0)        begin errors++; $display("FAIL spurious_tx_done_compute: got %0d want %0d", tx_cnt, t0); end
      @(negedge clk);
      core_digit = 4'd7;
      core_done  = 1'b1;
      @(negedge clk);
      core_done  = 1'b0;
      core_digit = 4'd0;
      #1;
      checks++; if (led !== 8'h07)        begin errors++; $display("FAIL class_led: got %h want 07", led); end
      checks++; if (tx_data !== 8'h37)    begin errors++; $display("FAIL class_tx_data: got %h want 37", tx_data); end
      @(negedge clk);
      #1;
      checks++; if (txs_cyc - done_cyc !== 1) begin errors++; $display("FAIL class_tx_latency: got %0d want 1", txs_cyc - done_cyc); end
      checks++; if (tx_cnt - t0 !== 1)    begin errors++; $display("FAIL class_tx_pulses: got %0d want 1", tx_cnt - t0); end
      checks++; if (clr_rx_rdy !== 1'b0)  begin errors++; $display("FAIL early_no_clr_wait_tx: got %b want 0", clr_rx_rdy); end
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      #1;
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL back_idle_busy: got %b want 0", busy); end
      checks++; if (clr_rx_rdy !== 1'b1)  begin errors++; $display("FAIL early_accept: got %b want 1", clr_rx_rdy); end
      w0 = wr_cnt;
      @(negedge clk);
      rx_rdy = 1'b0;
      repeat (9) @(negedge clk);
      checks++; if (byte_at(0) !== 8'h3C) begin errors++; $display("FAIL early_byte0: got %h want 3c", byte_at(0)); end
      checks++; if (wr_cnt - w0 !== 8)    begin errors++; $display("FAIL early_writes: got %0d want 8", wr_cnt - w0); end
      checks++; if (tx_data !== 8'h37)    begin errors++; $display("FAIL tx_data_hold: got %h want 37", tx_data); end
   endtask

   task automatic test_spurious();
      int s0, t0;
      s0 = start_cnt; t0 = tx_cnt;
      core_digit = 4'd3;
      core_done  = 1'b1;
      tx_done    = 1'b1;
      @(negedge clk);
      core_done  = 1'b0;
      tx_done    = 1'b0;
      core_digit = 4'd0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (led !== 8'h07)        begin errors++; $display("FAIL spurious_led: got %h want 07", led); end
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL spurious_busy: got %b want 0", busy); end
      checks++; if (tx_cnt !== t0 || start_cnt !== s0) begin
         errors++; $display("FAIL spurious_pulses: tx %0d start %0d want %0d %0d", tx_cnt, start_cnt, t0, s0);
      end
   endtask

   task automatic test_mid_frame_reset();
      int s0, w0;
      // 49 more bytes on top of the early byte: 50 bytes into the frame
      for (int k = 0; k < 49; k++) send_byte(8'hFF, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      checks++; if (led !== 8'h00)        begin errors++; $display("FAIL rst_mid_led: got %h want 00", led); end
      checks++; if (tx_data !== 8'h00)    begin errors++; $display("FAIL rst_mid_tx_data: got %h want 00", tx_data); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      s0 = start_cnt; w0 = wr_cnt;
      send_byte(8'hC3, 1);
      for (int k = 1; k < 97; k++) send_byte(8'h5A, k % 2);
      repeat (12) @(negedge clk);
      checks++; if (start_cnt !== s0)     begin errors++; $display("FAIL rst_mid_early_start: got %0d want %0d", start_cnt, s0); end
      send_byte(8'h81, 2);
      wait_start(s0);
      @(negedge clk);
      checks++; if (start_cyc - clr_cyc !== 9) begin errors++; $display("FAIL rst_mid_latency: got %0d want 9", start_cyc - clr_cyc); end
      checks++; if (wr_cnt - w0 !== 784)  begin errors++; $display("FAIL rst_mid_writes: got %0d want 784", wr_cnt - w0); end
      checks++; if (byte_at(0) !== 8'hC3) begin errors++; $display("FAIL rst_mid_byte0: got %h want c3", byte_at(0)); end
      checks++; if (byte_at(50) !== 8'h5A) begin errors++; $display("FAIL rst_mid_byte50: got %h want 5a", byte_at(50)); end
      checks++; if (byte_at(97) !== 8'h81) begin errors++; $display("FAIL rst_mid_byte97: got %h want 81", byte_at(97)); end
   endtask

   task automatic test_digit_wrap();
      core_digit = 4'hF;
      core_done  = 1'b1;
      @(negedge clk);
      core_done  = 1'b0;
      #1;
      checks++; if (tx_data !== 8'h3F)    begin errors++; $display("FAIL digit15_tx_data: got %h want 3f", tx_data); end
      checks++; if (led !== 8'h0F)        begin errors++; $display("FAIL digit15_led: got %h want 0f", led); end
      repeat (2) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      #1;
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL digit15_idle: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_frame_load();
      test_classify_early_byte();
      test_spurious();
      test_mid_frame_reset();
      test_digit_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
